// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and execution-stage FSM states.
// Purely declarative: no latency or backpressure of its own.
package alu_pkg;

   localparam logic [2:0] ALU_NOP = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_MUL = 3'b011;
   localparam logic [2:0] ALU_DIV = 3'b100;
   localparam logic [2:0] ALU_AND = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_RSV = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiply / restoring signed divide, one bit per step_i, WIDTH steps.
// No backpressure: the owning FSM sequences load_i/step_i and reads result_o in its FIX cycle.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   // acc: product (mul) or partial remainder (div)
   // opnd: shifted multiplicand (mul) or divisor magnitude (div)
   // sh: multiplier shifting right (mul) or dividend -> quotient (div)
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, rem_sub;

   // Magnitude of MIN_INT wraps back to itself, which is the correct unsigned value.
   assign a_mag   = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
   assign b_mag   = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
   assign rem_sh  = {acc_q, sh_q[WIDTH-1]};
   assign rem_sub = rem_sh - {1'b0, opnd_q};

   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      neg_d  = neg_q;
      dz_d   = dz_q;
      ovf_d  = ovf_q;
      if (load_i) begin
         acc_d = '0;
         cnt_d = '0;
         div_d = is_div_i;
         if (is_div_i) begin
            sh_d   = a_mag;
            opnd_d = b_mag;
            neg_d  = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            dz_d   = (b_i == '0);
            ovf_d  = (a_i == MIN_INT) && (b_i == '1);
         end else begin
            sh_d   = b_i;
            opnd_d = a_i;
            neg_d  = 1'b0;
            dz_d   = 1'b0;
            ovf_d  = 1'b0;
         end
      end else if (step_i) begin
         cnt_d = cnt_q + CW'(1);
         if (div_q) begin
            // A clear MSB on the trial subtraction means the divisor fit.
            if (!rem_sub[WIDTH]) begin
               acc_d = rem_sub[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (sh_q[0]) begin
               acc_d = acc_q + opnd_q;
            end
            opnd_d = {opnd_q[WIDTH-2:0], 1'b0};
            sh_d   = {1'b0, sh_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         opnd_q <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         dz_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         neg_q  <= neg_d;
         dz_q   <= dz_d;
         ovf_q  <= ovf_d;
      end
   end

   assign last_o = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      result_o = acc_q;
      if (div_q) begin
         if (dz_q)       result_o = '1;
         else if (ovf_q) result_o = MIN_INT;
         else if (neg_q) result_o = ~sh_q + 1'b1;
         else            result_o = sh_q;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: short ops done 1 cycle after accept, mul/div done WIDTH+2 cycles after accept.
// start is ignored while busy (no queueing); result/zero hold until the next done pulse.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       ALUop,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q;
   logic             done_q, done_d;

   logic             accept, is_long;
   logic             md_load, md_step, md_last;
   logic [WIDTH-1:0] md_result, short_res;

   assign accept  = start && (state_q == IDLE);
   assign is_long = (ALUop == ALU_MUL) || (ALUop == ALU_DIV);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && is_long) state_d = CALC;
         CALC:    if (md_last)           state_d = FIX;
         FIX:                            state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != IDLE);
      md_load = accept && is_long;
      md_step = (state_q == CALC);
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (md_load),
      .step_i   (md_step),
      .is_div_i (ALUop == ALU_DIV),
      .a_i      (operand_a),
      .b_i      (operand_b),
      .last_o   (md_last),
      .result_o (md_result)
   );

   always_comb begin
      case (ALUop)
         ALU_ADD: short_res = operand_a + operand_b;
         ALU_SUB: short_res = operand_a - operand_b;
         ALU_AND: short_res = operand_a & operand_b;
         ALU_OR:  short_res = operand_a | operand_b;
         default: short_res = '0;
      endcase
   end

   always_comb begin
      done_d   = 1'b0;
      result_d = result_q;
      if (accept && !is_long) begin
         done_d   = 1'b1;
         result_d = short_res;
      end else if (state_q == FIX) begin
         done_d   = 1'b1;
         result_d = md_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= done_d;
         if (done_d) begin
            result_q <= result_d;
            zero_q   <= (result_d == '0);
         end
      end
   end

   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with a queue scoreboard and an independent done monitor.
module tb_alu_exec_unit;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef struct {
      logic [31:0] res;
      int          due;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  ALUop;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb[$];

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ALUop     (ALUop),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got result %h with nothing outstanding (cyc %0d)", result, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_zero"}, {31'b0, zero}, {31'b0, (e.res == 32'h0)});
            chk({e.name, "_latency"}, cyc, e.due);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] exp, input int lat, input string nm);
      exp_t e;
      start     = 1'b1;
      ALUop     = op;
      operand_a = a;
      operand_b = b;
      if (push) begin
         e.res  = exp;
         e.due  = cyc + lat;
         e.name = nm;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int b = 0;
      while (sb.size() != 0 && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout: %0d responses still outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
      issue(op, a, b, 1'b1, exp, lat, nm);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; ALUop = OP_NOP; operand_a = '0; operand_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Leave a nonzero result so the mid-op reset visibly clears it.
      run_one(OP_OR, 32'h0000_000F, 32'h0000_0030, 32'h0000_003F, 1, "or");

      issue(OP_MUL, 32'd5, 32'd6, 1'b0, 32'd0, 0, "mul_rst");
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_zero", {31'b0, zero}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // Back-to-back short ops: consecutive single-cycle done pulses.
      issue(OP_ADD, 32'd7, 32'd5, 1'b1, 32'd12, 1, "add");
      @(negedge clk);
      issue(OP_SUB, 32'd9, 32'd9, 1'b1, 32'd0, 1, "sub");
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      run_one(OP_NOP, 32'd3, 32'd4, 32'd0, 1, "nop");
      run_one(OP_ADD, 32'd1, 32'd2, 32'd3, 1, "add_small");
      run_one(OP_RSV, 32'd3, 32'd4, 32'd0, 1, "reserved");
      run_one(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "add_wrap");
      run_one(OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, "sub_wrap");

      // Long op with busy profile: high for cycles 1..33 after issue, low in the done cycle.
      issue(OP_MUL, 32'hFFFF_FFFF, 32'd3, 1'b1, 32'hFFFF_FFFD, 34, "mul");
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         chk($sformatf("mul_busy_c%0d", k), {31'b0, busy}, {31'b0, (k <= 33)});
      end
      wait_idle();

      run_one(OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34, "mul_neg");
      run_one(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_neg");
      run_one(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_negb");
      run_one(OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 34, "div_negneg");
      run_one(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 34, "div_zero");
      run_one(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div_ovf");

      // Start while busy is dropped; start in the done cycle is accepted.
      issue(OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 34, "div_busy");
      n = cyc;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 5)  issue(OP_ADD, 32'd1, 32'd1, 1'b0, 32'd0, 0, "ignored");
         if (k == 34) issue(OP_AND, 32'h0000_00F0, 32'h0000_003C, 1'b1, 32'h0000_0030, 1, "and_b2b");
      end
      chk("b2b_issue_cycle", cyc, n + 34);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution stage fed directly by the ALU control decoder: it consumes the 3-bit ALU operation code plus two operands and produces a registered result and zero flag. Add/sub/and/or complete in one cycle. Multiply and divide run iteratively over WIDTH cycles behind a start/busy/done handshake, so the control path stalls the PC while `busy` is high. The zero flag drives the BEQ branch decision.

## Interface
- WIDTH, 32, operand/result width; also the iteration count for mul/div
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; operands and opcode are sampled when `start=1` and `busy=0`
- ALUop  input  3  000 nop, 001 add, 010 sub, 011 mul, 100 div, 101 and, 110 or, 111 reserved
- operand_a  input  WIDTH  first operand (rs1)
- operand_b  input  WIDTH  second operand (rs2 or immediate)
- busy  output  1  a long op is in progress; new `start` is ignored
- done  output  1  one-cycle pulse; `result` and `zero` are valid and updated this cycle
- result  output  WIDTH  last completed result; held until the next `done`
- zero  output  1  (result == 0), registered together with `result`

## Operation
- Reset, asserted at any time: state IDLE, busy=0, done=0, result=0, zero=1 (matches result=0), counter=0. An in-flight op is discarded and produces no `done`.
- FSM states:
  - IDLE:
    - short op (000, 001, 010, 101, 110, 111) accepted -> compute, register result, pulse done; remain IDLE.
    - 011 or 100 accepted -> load datapath, counter=0; go to CALC.
  - CALC: one iteration per cycle; counter increments; after iteration WIDTH-1 go to FIX.
  - FIX: apply sign and special-case fixup, register result, pulse done; go to IDLE.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow flag.
  - nop and reserved give result 0.
  - mul: shift-add, unsigned; returns the low WIDTH bits, which equals the signed low product.
  - div: signed quotient, truncated toward zero. Restoring division runs on magnitudes; the quotient is negated in FIX if the operand signs differ.
  - div by zero: result all-ones (-1).
  - div of MIN_INT by -1: result MIN_INT.
  - Both special cases still take the full latency.
- `start` while busy=1 is ignored, with no queueing. Operand changes during CALC/FIX have no effect because operands are latched at accept.

## Timing
- Short op: start sampled at edge E0; done=1 with result in the cycle after E0 (latency 1); busy stays 0.
- Long op: accept at E0; iterations at E1..EWIDTH; FIX at EWIDTH+1. done is high in the cycle after EWIDTH+1, which is 34 cycles after start for WIDTH=32.
- busy is 1 from the cycle after accept through the FIX cycle. It is 0 in the done cycle, so a back-to-back start is accepted in the done cycle.
- done is never high for two consecutive cycles from one request. Consecutive short ops give consecutive single-cycle pulses.
- result/zero change only on a done edge or on reset.

## Structure
- Package `alu_pkg`:
  - localparams for the ALUop codes (ALU_NOP, ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_AND, ALU_OR), shared with the ALU control decoder.
  - FSM state encoding (IDLE, CALC, FIX).
- Sub-module `alu_muldiv_iter`:
  - owns the accumulator, shift registers, counter ($clog2(WIDTH)+1 bits) and sign/special-case fixup.
  - the top level holds the FSM, the short-op logic and the output registers.

## Test plan
- Reset mid-op: reset after mul start, at cycle 10 -> busy=0 and result=0 immediately; no done pulse follows.
- add 7+5 -> done next cycle, result=12, zero=0. Then sub 9-9 -> result=0, zero=1.
- mul 0xFFFFFFFF*3 -> done at start+34, result=0xFFFFFFFD; busy high cycles 1..33.
- div -7/2 -> result=0xFFFFFFFD (-3).
- div special cases: 5/0 -> 0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> 0x80000000; both at start+34.
- Start while busy: add issued at cycle 5 of a div is ignored, with the div result unaffected. Then a start in the done cycle: and 0xF0&0x3C is accepted -> result=0x30 one cycle later.
